mcs_pcstack: RTL and testbench

MCS_PCSTACK -- requirements
Module: mcs_pcstack

---
 rtl/mcs_pkg.sv | 6 +
 rtl/mcs_pcstack_ram.sv | 14 +
 rtl/mcs_pcstack.sv | 106 ++++++++++
 tb/tb_mcs_pcstack.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcs_pkg.sv
// mcs_pkg: command codes, FSM states and restart-vector placement shared by the PC stack.
package mcs_pkg;
   typedef enum logic [2:0] {CMD_NOP, CMD_INC, CMD_LDL, CMD_LDH, CMD_JMP, CMD_CALL, CMD_RET, CMD_RST} cmdT;
   typedef enum logic [1:0] {ST_IDLE, ST_PUSH2, ST_POP2} stateT;
   localparam int RSTV_SHIFT = 3;
endpackage

// File: rtl/mcs_pcstack_ram.sv
// mcs_pcstack_ram: return-address storage, single port, synchronous write, registered read.
module mcs_pcstack_ram #(parameter int AW = 14, parameter int N = 7, parameter int AB = 3) (
   input  logic clk,
   input  logic we,
   input  logic [AB-1:0] addr,
   input  logic [AW-1:0] wdat,
   output logic [AW-1:0] rdat
);
   logic [AW-1:0] mem [N];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdat;
      rdat <= mem[addr];
   end
endmodule

// File: rtl/mcs_pcstack.sv
// mcs_pcstack: program counter with target latch and return-address stack.
// CALL/RST/RET take two cycles; the second cycle loads the PC from the latched target or the RAM.
module mcs_pcstack
   import mcs_pkg::*;
#(parameter int AW = 14, parameter int DEPTH = 8, parameter int WRAP = 1) (
   input  logic CLK_I,
   input  logic nRST_I,
   input  logic CMD_VLD_I,
   input  logic [2:0] CMD_I,
   input  logic COND_I,
   input  logic [7:0] DAT_I,
   input  logic [2:0] RSTV_I,
   input  logic ERR_CLR_I,
   output logic CMD_RDY_O,
   output logic [AW-1:0] PC_O,
   output logic [7:0] PCL_O,
   output logic [7:0] PCH_O,
   output logic [$clog2(DEPTH)-1:0] LVL_O,
   output logic OVF_O,
   output logic UDF_O
);
   localparam int LW = $clog2(DEPTH);
   localparam logic [LW-1:0] TOP = LW'(DEPTH - 1);
   localparam logic [LW-1:0] SPMAX = LW'(DEPTH - 2);
   stateT state;
   logic [AW-1:0] pc, t, tgt, ramRdat;
   logic [LW-1:0] sp, lvl, spInc, spDec, ramAddr;
   logic rdy, ovf, udf, acc, isCall, isRet, full, empty, doPush, doPop;
   assign acc = CMD_VLD_I & rdy;
   assign isCall = acc & (((CMD_I == CMD_CALL) & COND_I) | (CMD_I == CMD_RST));
   assign isRet = acc & (CMD_I == CMD_RET) & COND_I;
   assign full = lvl == TOP;
   assign empty = lvl == '0;
   assign doPush = isCall & ((WRAP != 0) | !full);
   assign doPop = isRet & ((WRAP != 0) | !empty);
   // SP circulates over the DEPTH-1 storage entries
   assign spInc = (sp == SPMAX) ? '0 : sp + LW'(1);
   assign spDec = (sp == '0) ? SPMAX : sp - LW'(1);
   assign ramAddr = isRet ? spDec : sp;
   mcs_pcstack_ram #(.AW(AW), .N(DEPTH - 1), .AB(LW)) uRam (
      .clk(CLK_I),
      .we(doPush),
      .addr(ramAddr),
      .wdat(pc),
      .rdat(ramRdat)
   );
   always_ff @(posedge CLK_I) begin
      if (!nRST_I) begin
         state <= ST_IDLE;
         rdy <= 1'b1;
         pc <= '0;
         t <= '0;
         tgt <= '0;
         sp <= '0;
         lvl <= '0;
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         // a fresh error in the same cycle as a clear keeps the flag set
         ovf <= (isCall & full) | (ovf & ~ERR_CLR_I);
         udf <= (isRet & empty) | (udf & ~ERR_CLR_I);
         case (state)
            ST_IDLE: begin
               if (acc & (CMD_I == CMD_INC)) pc <= pc + AW'(1);
               if (acc & (CMD_I == CMD_JMP) & COND_I) pc <= t;
               if (acc & (CMD_I == CMD_LDL)) t[7:0] <= DAT_I;
               if (acc & (CMD_I == CMD_LDH)) t[AW-1:8] <= DAT_I[AW-9:0];
               if (doPush) begin
                  sp <= spInc;
                  lvl <= full ? lvl : lvl + LW'(1);
                  tgt <= (CMD_I == CMD_RST) ? (AW'(RSTV_I) << RSTV_SHIFT) : t;
                  state <= ST_PUSH2;
                  rdy <= 1'b0;
               end
               if (doPop) begin
                  sp <= spDec;
                  lvl <= empty ? lvl : lvl - LW'(1);
                  state <= ST_POP2;
                  rdy <= 1'b0;
               end
            end
            ST_PUSH2: begin
               pc <= tgt;
               state <= ST_IDLE;
               rdy <= 1'b1;
            end
            ST_POP2: begin
               pc <= ramRdat;
               state <= ST_IDLE;
               rdy <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               rdy <= 1'b1;
            end
         endcase
      end
   end
   assign CMD_RDY_O = rdy;
   assign PC_O = pc;
   assign PCL_O = pc[7:0];
   assign PCH_O = 8'(pc >> 8);
   assign LVL_O = lvl;
   assign OVF_O = ovf;
   assign UDF_O = udf;
endmodule

// File: tb/tb_mcs_pcstack.sv
// tb_mcs_pcstack: guarded (index 0) and circular (index 1) stacks driven in lockstep,
// each checked against a transaction-level model of the command set.
module tb_mcs_pcstack;
   localparam int AW = 14;
   localparam int D = 8;
   logic clk = 1'b0;
   logic nRst, cmdVld, cond, errClr;
   logic [2:0] cmd, rstv;
   logic [7:0] dat;
   logic [1:0] rdyO, ovfO, udfO;
   logic [1:0][AW-1:0] pcO;
   logic [1:0][7:0] pclO, pchO;
   logic [1:0][2:0] lvlO;
   int mPc[2], mT[2], mSp[2], mLvl[2], mOvf[2], mUdf[2];
   int mMem[2][D-1];
   int lat[2];
   logic [1:0] firstRdy;
   int nVec = 0, nBad = 0;
   always #5 clk = ~clk;
   mcs_pcstack #(.AW(AW), .DEPTH(D), .WRAP(0)) u0 (
      .CLK_I(clk), .nRST_I(nRst), .CMD_VLD_I(cmdVld), .CMD_I(cmd), .COND_I(cond), .DAT_I(dat),
      .RSTV_I(rstv), .ERR_CLR_I(errClr), .CMD_RDY_O(rdyO[0]), .PC_O(pcO[0]), .PCL_O(pclO[0]),
      .PCH_O(pchO[0]), .LVL_O(lvlO[0]), .OVF_O(ovfO[0]), .UDF_O(udfO[0])
   );
   mcs_pcstack #(.AW(AW), .DEPTH(D), .WRAP(1)) u1 (
      .CLK_I(clk), .nRST_I(nRst), .CMD_VLD_I(cmdVld), .CMD_I(cmd), .COND_I(cond), .DAT_I(dat),
      .RSTV_I(rstv), .ERR_CLR_I(errClr), .CMD_RDY_O(rdyO[1]), .PC_O(pcO[1]), .PCL_O(pclO[1]),
      .PCH_O(pchO[1]), .LVL_O(lvlO[1]), .OVF_O(ovfO[1]), .UDF_O(udfO[1])
   );
   // whole-command effect; w doubles as the WRAP setting of that instance
   task automatic model(input int w, input int c, input int cnd, input int d, input int rv, input int clr);
      int nO, nU;
      nO = 0;
      nU = 0;
      lat[w] = 1;
      if (c == 1) mPc[w] = (mPc[w] + 1) % (1 << AW);
      if (c == 2) mT[w] = (mT[w] & ~255) | d;
      if (c == 3) mT[w] = (mT[w] & 255) | ((d % (1 << (AW - 8))) << 8);
      if (c == 4 && cnd != 0) mPc[w] = mT[w];
      if (c == 7 || (c == 5 && cnd != 0)) begin
         nO = (mLvl[w] == D - 1) ? 1 : 0;
         if (w == 1 || nO == 0) begin
            mMem[w][mSp[w]] = mPc[w];
            mSp[w] = (mSp[w] + 1) % (D - 1);
            if (nO == 0) mLvl[w]++;
            mPc[w] = (c == 7) ? rv * 8 : mT[w];
            lat[w] = 2;
         end
      end
      if (c == 6 && cnd != 0) begin
         nU = (mLvl[w] == 0) ? 1 : 0;
         if (w == 1 || nU == 0) begin
            mSp[w] = (mSp[w] + D - 2) % (D - 1);
            mPc[w] = mMem[w][mSp[w]];
            if (nU == 0) mLvl[w]--;
            lat[w] = 2;
         end
      end
      mOvf[w] = (nO != 0 || (mOvf[w] != 0 && clr == 0)) ? 1 : 0;
      mUdf[w] = (nU != 0 || (mUdf[w] != 0 && clr == 0)) ? 1 : 0;
   endtask
   task automatic doReset();
      @(negedge clk);
      nRst = 1'b0;
      cmdVld = 1'b0;
      errClr = 1'b0;
      @(negedge clk);
      nRst = 1'b1;
      for (int w = 0; w < 2; w++) begin
         mPc[w] = 0;
         mT[w] = 0;
         mSp[w] = 0;
         mLvl[w] = 0;
         mOvf[w] = 0;
         mUdf[w] = 0;
      end
   endtask
   // one accepted command; optionally keeps it presented while both instances are busy
   task automatic doCmd(input int c, input int cnd, input int d, input int rv, input int clr, input int hold);
      for (int w = 0; w < 2; w++) model(w, c, cnd, d, rv, clr);
      @(negedge clk);
      cmdVld = 1'b1;
      cmd = 3'(c);
      cond = (cnd != 0);
      dat = 8'(d);
      rstv = 3'(rv);
      errClr = (clr != 0);
      @(negedge clk);
      firstRdy = rdyO;
      errClr = 1'b0;
      cmdVld = (hold != 0 && lat[0] == 2 && lat[1] == 2);
      if (lat[0] == 2 || lat[1] == 2) begin
         @(negedge clk);
         cmdVld = 1'b0;
      end
   endtask
   task automatic test_reset();
      doReset();
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (rdyO[w] !== 1'b1 || pcO[w] !== '0 || lvlO[w] !== '0 || ovfO[w] !== 1'b0 || udfO[w] !== 1'b0) begin
            nBad++;
            $display("FAIL reset w%0d: rdy=%b pc=%h lvl=%0d ovf=%b udf=%b, want rdy=1 pc=0 lvl=0 ovf=0 udf=0",
                     w, rdyO[w], pcO[w], lvlO[w], ovfO[w], udfO[w]);
         end
      end
      doCmd(1, 0, 0, 0, 0, 0);
      doCmd(4, 1, 0, 0, 0, 0);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (pcO[w] !== '0) begin
            nBad++;
            $display("FAIL reset_target w%0d: pc=%h, want 0", w, pcO[w]);
         end
      end
   endtask
   task automatic test_inc();
      for (int i = 0; i < 3; i++) begin
         doCmd(1, 0, 0, 0, 0, 0);
         for (int w = 0; w < 2; w++) begin
            nVec++;
            if (firstRdy[w] !== 1'b1 || rdyO[w] !== 1'b1 || pcO[w] !== AW'(i + 1) || lvlO[w] !== '0) begin
               nBad++;
               $display("FAIL inc w%0d: rdy=%b/%b pc=%h lvl=%0d, want rdy=1/1 pc=%h lvl=0",
                        w, firstRdy[w], rdyO[w], pcO[w], lvlO[w], i + 1);
            end
         end
      end
   endtask
   task automatic test_call_ret();
      doCmd(2, 0, 'h34, 0, 0, 0);
      doCmd(3, 0, 'h12, 0, 0, 0);
      doCmd(5, 1, 0, 0, 0, 1);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (firstRdy[w] !== 1'b0 || rdyO[w] !== 1'b1 || pcO[w] !== 14'h1234 || lvlO[w] !== 3'd1) begin
            nBad++;
            $display("FAIL call w%0d: rdy=%b/%b pc=%h lvl=%0d, want rdy=0/1 pc=1234 lvl=1",
                     w, firstRdy[w], rdyO[w], pcO[w], lvlO[w]);
         end
      end
      doCmd(6, 1, 0, 0, 0, 0);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (firstRdy[w] !== 1'b0 || pcO[w] !== 14'h0003 || lvlO[w] !== 3'd0) begin
            nBad++;
            $display("FAIL ret w%0d: rdy=%b pc=%h lvl=%0d, want rdy=0 pc=0003 lvl=0", w, firstRdy[w], pcO[w], lvlO[w]);
         end
      end
   endtask
   task automatic test_pc_wrap();
      doCmd(2, 0, 'hFF, 0, 0, 0);
      doCmd(3, 0, 'h3F, 0, 0, 0);
      doCmd(4, 1, 0, 0, 0, 0);
      doCmd(1, 0, 0, 0, 0, 0);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (pcO[w] !== '0) begin
            nBad++;
            $display("FAIL inc_wrap w%0d: pc=%h, want 0000", w, pcO[w]);
         end
      end
      doCmd(7, 0, 0, 5, 0, 0);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (pcO[w] !== 14'h0028 || pchO[w] !== 8'h00 || pclO[w] !== 8'h28 || firstRdy[w] !== 1'b0) begin
            nBad++;
            $display("FAIL rst_vec w%0d: pc=%h pch=%h pcl=%h rdy=%b, want pc=0028 pch=00 pcl=28 rdy=0",
                     w, pcO[w], pchO[w], pclO[w], firstRdy[w]);
         end
      end
   endtask
   task automatic test_overflow();
      int pcBefore;
      doReset();
      for (int i = 0; i < 8; i++) begin
         pcBefore = mPc[0];
         doCmd(2, 0, int'($urandom_range(0, 255)), 0, 0, 0);
         doCmd(3, 0, int'($urandom_range(0, 255)), 0, 0, 0);
         doCmd(5, 1, 0, 0, 0, 0);
      end
      nVec++;
      if (ovfO[0] !== 1'b1 || pcO[0] !== AW'(pcBefore) || lvlO[0] !== 3'd7 || firstRdy[0] !== 1'b1) begin
         nBad++;
         $display("FAIL ovf_guard: ovf=%b pc=%h lvl=%0d rdy=%b, want ovf=1 pc=%h lvl=7 rdy=1",
                  ovfO[0], pcO[0], lvlO[0], firstRdy[0], pcBefore);
      end
      nVec++;
      if (ovfO[1] !== 1'b1 || pcO[1] !== AW'(mPc[1]) || lvlO[1] !== 3'd7 || firstRdy[1] !== 1'b0) begin
         nBad++;
         $display("FAIL ovf_wrap: ovf=%b pc=%h lvl=%0d rdy=%b, want ovf=1 pc=%h lvl=7 rdy=0",
                  ovfO[1], pcO[1], lvlO[1], firstRdy[1], mPc[1]);
      end
      doCmd(0, 0, 0, 0, 1, 0);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (ovfO[w] !== 1'b0) begin
            nBad++;
            $display("FAIL ovf_clr w%0d: ovf=%b, want 0", w, ovfO[w]);
         end
      end
      for (int i = 0; i < 7; i++) begin
         doCmd(6, 1, 0, 0, 0, 0);
         for (int w = 0; w < 2; w++) begin
            nVec++;
            if (pcO[w] !== AW'(mPc[w]) || lvlO[w] !== 3'(mLvl[w])) begin
               nBad++;
               $display("FAIL unwind w%0d #%0d: pc=%h lvl=%0d, want pc=%h lvl=%0d", w, i, pcO[w], lvlO[w], mPc[w], mLvl[w]);
            end
         end
      end
   endtask
   task automatic test_underflow();
      int pcBefore;
      pcBefore = mPc[0];
      doCmd(6, 1, 0, 0, 0, 0);
      nVec++;
      if (udfO[0] !== 1'b1 || pcO[0] !== AW'(pcBefore) || lvlO[0] !== '0 || firstRdy[0] !== 1'b1) begin
         nBad++;
         $display("FAIL udf_guard: udf=%b pc=%h lvl=%0d rdy=%b, want udf=1 pc=%h lvl=0 rdy=1",
                  udfO[0], pcO[0], lvlO[0], firstRdy[0], pcBefore);
      end
      nVec++;
      if (udfO[1] !== 1'b1 || pcO[1] !== AW'(mPc[1]) || lvlO[1] !== '0 || firstRdy[1] !== 1'b0) begin
         nBad++;
         $display("FAIL udf_wrap: udf=%b pc=%h lvl=%0d rdy=%b, want udf=1 pc=%h lvl=0 rdy=0",
                  udfO[1], pcO[1], lvlO[1], firstRdy[1], mPc[1]);
      end
      doCmd(6, 1, 0, 0, 1, 0);
      doCmd(0, 0, 0, 0, 0, 0);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (udfO[w] !== 1'b1) begin
            nBad++;
            $display("FAIL udf_clr_race w%0d: udf=%b, want 1", w, udfO[w]);
         end
      end
      doCmd(0, 0, 0, 0, 1, 0);
      for (int w = 0; w < 2; w++) begin
         pcBefore = mPc[w];
         nVec++;
         if (udfO[w] !== 1'b0) begin
            nBad++;
            $display("FAIL udf_clr w%0d: udf=%b, want 0", w, udfO[w]);
         end
      end
      doCmd(4, 0, 0, 0, 0, 0);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (pcO[w] !== AW'(mPc[w]) || firstRdy[w] !== 1'b1) begin
            nBad++;
            $display("FAIL jmp_not_taken w%0d: pc=%h rdy=%b, want pc=%h rdy=1", w, pcO[w], firstRdy[w], mPc[w]);
         end
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         doCmd(int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 255)),
               int'($urandom_range(0, 7)), ($urandom_range(0, 11) == 0) ? 1 : 0, int'($urandom_range(0, 1)));
         for (int w = 0; w < 2; w++) begin
            nVec++;
            if (pcO[w] !== AW'(mPc[w]) || pclO[w] !== 8'(mPc[w]) || pchO[w] !== 8'(mPc[w] >> 8) ||
                lvlO[w] !== 3'(mLvl[w]) || ovfO[w] !== 1'(mOvf[w]) || udfO[w] !== 1'(mUdf[w]) ||
                firstRdy[w] !== (lat[w] == 1) || rdyO[w] !== 1'b1) begin
               nBad++;
               $display("FAIL random w%0d #%0d cmd=%0d: pc=%h pcl=%h pch=%h lvl=%0d ovf=%b udf=%b rdy=%b/%b, want pc=%h lvl=%0d ovf=%0d udf=%0d rdy=%0d/1",
                        w, i, cmd, pcO[w], pclO[w], pchO[w], lvlO[w], ovfO[w], udfO[w], firstRdy[w], rdyO[w],
                        mPc[w], mLvl[w], mOvf[w], mUdf[w], lat[w] == 1);
            end
         end
      end
   endtask
   task automatic test_reset_push2();
      doCmd(2, 0, 'hA5, 0, 0, 0);
      doCmd(6, 1, 0, 0, 0, 0);
      doCmd(6, 1, 0, 0, 0, 0);
      @(negedge clk);
      cmdVld = 1'b1;
      cmd = 3'd5;
      cond = 1'b1;
      @(negedge clk);
      cmdVld = 1'b0;
      nRst = 1'b0;
      @(negedge clk);
      nRst = 1'b1;
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (rdyO[w] !== 1'b1 || pcO[w] !== '0 || lvlO[w] !== '0 || ovfO[w] !== 1'b0 || udfO[w] !== 1'b0) begin
            nBad++;
            $display("FAIL reset_push2 w%0d: rdy=%b pc=%h lvl=%0d ovf=%b udf=%b, want rdy=1 pc=0 lvl=0 flags=0",
                     w, rdyO[w], pcO[w], lvlO[w], ovfO[w], udfO[w]);
         end
      end
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         nVec++;
         if (pcO[w] !== '0 || rdyO[w] !== 1'b1) begin
            nBad++;
            $display("FAIL reset_push2_hold w%0d: pc=%h rdy=%b, want pc=0 rdy=1", w, pcO[w], rdyO[w]);
         end
      end
   endtask
   initial begin
      nRst = 1'b0;
      cmdVld = 1'b0;
      cmd = '0;
      cond = 1'b0;
      dat = '0;
      rstv = '0;
      errClr = 1'b0;
      test_reset();
      test_inc();
      test_call_ret();
      test_pc_wrap();
      test_overflow();
      test_underflow();
      test_random();
      test_reset_push2();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end
endmodule
